cu_memory_arbiter: RTL and testbench
====================================

# cu_memory_arbiter

Shares the single-port main memory between the control unit (micro-op driven MAR/MBR accesses) and the program loader. Each requester uses a request/acknowledge handshake. Contention is resolved round-robin, and the memory access runs for a fixed, parameterised number of wait states. While a CPU access is pending, the block raises a stall that the control unit uses to freeze the CAR (control word treated as 2'b00), so micro-sequencing resumes exactly when data is valid.

## Interface
- ADDR_W, 8: memory address width
- DATA_W, 16: memory data width
- WAIT_CYCLES, 1: extra access cycles beyond the first; 0 is legal
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_cpu_req / i_cpu_we  in  1 / 1  CPU request, write enable
- i_cpu_addr / i_cpu_wdata  in  ADDR_W / DATA_W  CPU address, write data
- o_cpu_rdata  out  DATA_W  CPU read data, valid while o_cpu_ack
- o_cpu_ack  out  1  one-cycle completion pulse to CPU
- o_cpu_stall  out  1  i_cpu_req & ~o_cpu_ack (combinational)
- i_ldr_req / i_ldr_we  in  1 / 1  loader request, write enable
- i_ldr_addr / i_ldr_wdata  in  ADDR_W / DATA_W  loader address, write data
- o_ldr_rdata / o_ldr_ack  out  DATA_W / 1  loader read data, completion pulse
- o_mem_en / o_mem_we  out  1 / 1  memory enable, write enable
- o_mem_addr / o_mem_wdata  out  ADDR_W / DATA_W  memory address, write data
- i_mem_rdata  in  DATA_W  memory read data, valid on last access cycle
- o_owner  out  2  00 none, 01 CPU, 10 loader

## Operation
- FSM states:
  - IDLE: no transaction.
  - ACCESS: WAIT_CYCLES+1 cycles.
  - ACK: 1 cycle.
- IDLE: sample both requests.
  - No request: stay in IDLE.
  - One request: grant that requester.
  - Both requesting: grant the requester not served last (last_grant flag). After reset, last_grant = loader, so the CPU wins the first tie.
- On grant:
  - Latch we/addr/wdata and owner into internal registers.
  - Reload the wait counter (width $clog2(WAIT_CYCLES+1), minimum 1) to WAIT_CYCLES.
  - Go to ACCESS.
  - Update last_grant.
- ACCESS:
  - o_mem_en=1.
  - o_mem_we/addr/wdata are driven from the latched values.
  - o_owner equals the latched owner.
  - The counter decrements each cycle.
  - At counter==0, a read captures i_mem_rdata into the owner's rdata register, and the FSM goes to ACK.
- ACK:
  - The owner's ack=1 for exactly one cycle.
  - o_mem_en=0 and o_owner holds.
  - Next state is IDLE unconditionally; requests are not sampled in ACK.
- Requester rule: hold req and all request fields stable until ack is seen, then deassert req at that same clock edge. A req still high in IDLE is a new request.
- Writes leave o_*_rdata unchanged. o_*_rdata holds its last captured value between reads.
- Changes to requester inputs during ACCESS/ACK are ignored because the request is latched.
- The non-owner's ack is never asserted. Its stall (CPU) stays high for the whole foreign transaction.

## Timing
- Reset values:
  - state=IDLE, last_grant=loader.
  - o_mem_en/we/addr/wdata=0.
  - o_cpu_rdata/o_ldr_rdata=0, both acks=0, o_owner=00.
  - o_cpu_stall follows i_cpu_req.
- Latency: req sampled in IDLE at edge t → ACCESS cycles t+1..t+1+WAIT_CYCLES → ack high in cycle t+2+WAIT_CYCLES.
- Throughput: one transaction per WAIT_CYCLES+3 cycles (IDLE, ACCESS, ACK).
- Reset mid-ACCESS or mid-ACK:
  - Abort at the next edge with no ack.
  - o_mem_en drops immediately after that edge.
  - The latched request is discarded.
- Simultaneous arrival while busy: the waiting requester is served in the next IDLE. Under continuous contention, the round-robin guarantees it is not starved.

## Structure
- cu_pkg holds:
  - State enum: IDLE, ACCESS, ACK.
  - Owner encoding constants: OWN_NONE=2'b00, OWN_CPU=2'b01, OWN_LDR=2'b10.
- Sub-module rr_arbiter2:
  - Two-input round-robin grant with a registered last_grant.
  - Updated only on an accepted grant.

## Test plan
- Reset, then CPU read of addr 0x10 (mem holds 0x1234), WAIT_CYCLES=1:
  - o_mem_en high for 2 cycles.
  - o_cpu_ack on the 3rd cycle after sampling, with o_cpu_rdata=0x1234.
  - o_cpu_stall high until the ack cycle.
- Loader write 0xBEEF to 0x20:
  - o_mem_we=1, addr=0x20, wdata=0xBEEF for the ACCESS cycles.
  - o_ldr_ack pulses once.
  - o_cpu_rdata unchanged.
- Both request in the same IDLE after reset:
  - CPU is served first (o_owner=01), then the loader (o_owner=10).
  - Repeat with both requesting continuously: grants alternate CPU, LDR, CPU, LDR.
- WAIT_CYCLES=0: read completes with o_mem_en for 1 cycle and ack 2 cycles after sampling.
- Assert i_rst in the 2nd ACCESS cycle:
  - No ack is issued.
  - All outputs return to their reset values.
  - The next CPU request is granted first.
- Change i_cpu_addr from 0x10 to 0x30 during ACCESS: o_mem_addr stays 0x10.

Source files
------------

// File: rtl/cu_pkg.sv
// cu_pkg: shared FSM state type and owner encodings for the memory arbiter
package cu_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_LDR  = 2'b10;
endpackage

// File: rtl/cu_memory_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-input round-robin grant; last_grant resets to loader so the CPU wins the first tie
module rr_arbiter2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req_cpu,
  input  logic i_req_ldr,
  input  logic i_accept,
  output logic o_gnt_cpu,
  output logic o_gnt_ldr
);
  logic last_ldr;
  assign o_gnt_cpu = i_req_cpu & (~i_req_ldr | last_ldr);
  assign o_gnt_ldr = i_req_ldr & ~o_gnt_cpu;
  always_ff @(posedge i_clk)
    last_ldr <= i_rst ? 1'b1 : i_accept ? o_gnt_ldr : last_ldr;
endmodule

// File: rtl/cu_memory_arbiter.sv
// cu_memory_arbiter: round-robin sharing of single-port memory between CPU and loader with fixed wait states
module cu_memory_arbiter
  import cu_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_ack,
  output logic              o_cpu_stall,
  input  logic              i_ldr_req,
  input  logic              i_ldr_we,
  input  logic [ADDR_W-1:0] i_ldr_addr,
  input  logic [DATA_W-1:0] i_ldr_wdata,
  output logic [DATA_W-1:0] o_ldr_rdata,
  output logic              o_ldr_ack,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [1:0]        o_owner
);
  localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [1:0] owner;
  logic gnt_cpu, gnt_ldr, grant, done;
  assign grant = state == IDLE && (i_cpu_req || i_ldr_req);
  assign done = state == ACCESS && cnt == '0;
  assign o_owner = owner;
  rr_arbiter2 u_rr (
    .i_clk,
    .i_rst,
    .i_req_cpu(i_cpu_req),
    .i_req_ldr(i_ldr_req),
    .i_accept (grant),
    .o_gnt_cpu(gnt_cpu),
    .o_gnt_ldr(gnt_ldr)
  );
  always_ff @(posedge i_clk)
    state <= i_rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE ? (grant ? ACCESS : IDLE) : state == ACCESS ? (done ? ACK : ACCESS) : IDLE;
    o_mem_en = state == ACCESS;
    o_mem_we = o_mem_en & lat_we;
    o_mem_addr = o_mem_en ? lat_addr : '0;
    o_mem_wdata = o_mem_en ? lat_wdata : '0;
    o_cpu_ack = state == ACK && owner == OWN_CPU;
    o_ldr_ack = state == ACK && owner == OWN_LDR;
    o_cpu_stall = i_cpu_req & ~o_cpu_ack;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
      lat_we <= 1'b0;
      lat_addr <= '0;
      lat_wdata <= '0;
      owner <= OWN_NONE;
      o_cpu_rdata <= '0;
      o_ldr_rdata <= '0;
    end else begin
      if (grant) begin
        lat_we <= gnt_cpu ? i_cpu_we : i_ldr_we;
        lat_addr <= gnt_cpu ? i_cpu_addr : i_ldr_addr;
        lat_wdata <= gnt_cpu ? i_cpu_wdata : i_ldr_wdata;
        owner <= gnt_ldr ? OWN_LDR : OWN_CPU;
        cnt <= CW'(WAIT_CYCLES);
      end else if (state == ACCESS && !done) begin
        cnt <= cnt - CW'(1);
      end
      if (state == ACK) owner <= OWN_NONE;
      if (done && !lat_we && owner == OWN_CPU) o_cpu_rdata <= i_mem_rdata;
      if (done && !lat_we && owner == OWN_LDR) o_ldr_rdata <= i_mem_rdata;
    end
  end
endmodule

// File: tb/tb_cu_memory_arbiter.sv
// tb_cu_memory_arbiter: transaction-level model plus directed checks for the memory arbiter
module tb_cu_memory_arbiter;
  localparam int W = 1;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0;
  logic [7:0] cpu_addr = '0, ldr_addr = '0, mem_addr;
  logic [15:0] cpu_wdata = '0, ldr_wdata = '0, cpu_rdata, ldr_rdata, mem_wdata, mem_rdata;
  logic cpu_ack, cpu_stall, ldr_ack, mem_en, mem_we;
  logic [1:0] owner;
  logic [15:0] mem [256];
  assign mem_rdata = mem[mem_addr];
  cu_memory_arbiter #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_ack(cpu_ack), .o_cpu_stall(cpu_stall),
    .i_ldr_req(ldr_req), .i_ldr_we(ldr_we), .i_ldr_addr(ldr_addr), .i_ldr_wdata(ldr_wdata),
    .o_ldr_rdata(ldr_rdata), .o_ldr_ack(ldr_ack),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_owner(owner)
  );
  logic c0_req = 0;
  logic [7:0] c0_addr = '0, m0_addr;
  logic [15:0] c0_rdata, l0_rdata, m0_wdata, m0_rdata;
  logic c0_ack, c0_stall, l0_ack, m0_en, m0_we;
  logic [1:0] owner0;
  assign m0_rdata = mem[m0_addr];
  cu_memory_arbiter #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(c0_req), .i_cpu_we(1'b0), .i_cpu_addr(c0_addr), .i_cpu_wdata(16'h0),
    .o_cpu_rdata(c0_rdata), .o_cpu_ack(c0_ack), .o_cpu_stall(c0_stall),
    .i_ldr_req(1'b0), .i_ldr_we(1'b0), .i_ldr_addr(8'h0), .i_ldr_wdata(16'h0),
    .o_ldr_rdata(l0_rdata), .o_ldr_ack(l0_ack),
    .o_mem_en(m0_en), .o_mem_we(m0_we), .o_mem_addr(m0_addr), .o_mem_wdata(m0_wdata),
    .i_mem_rdata(m0_rdata), .o_owner(owner0)
  );
  always @(posedge clk)
    if (rst) begin
      mem[8'h10] <= 16'h1234;
      mem[8'h20] <= 16'h0000;
      mem[8'h30] <= 16'h5678;
    end else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
  int checks = 0, errors = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
    end
  endtask
  logic m_busy, m_last_ldr, m_we;
  int m_k;
  logic [1:0] m_own;
  logic [7:0] m_addr;
  logic [15:0] m_wdata, m_cpu_rd, m_ldr_rd;
  logic [15:0] mmem [256];
  wire m_cpu_wins = cpu_req && (!ldr_req || m_last_ldr);
  wire e_en = m_busy && m_k <= W + 1;
  wire e_cack = m_busy && m_k == W + 2 && m_own == 2'b01;
  wire e_lack = m_busy && m_k == W + 2 && m_own == 2'b10;
  always @(posedge clk)
    if (rst) begin
      m_busy <= 0; m_k <= 0; m_own <= 0; m_last_ldr <= 1;
      m_we <= 0; m_addr <= 0; m_wdata <= 0; m_cpu_rd <= 0; m_ldr_rd <= 0;
      mmem[8'h10] <= 16'h1234;
      mmem[8'h20] <= 16'h0000;
      mmem[8'h30] <= 16'h5678;
    end else if (!m_busy) begin
      if (cpu_req || ldr_req) begin
        m_busy <= 1;
        m_k <= 1;
        m_own <= m_cpu_wins ? 2'b01 : 2'b10;
        m_last_ldr <= !m_cpu_wins;
        m_we <= m_cpu_wins ? cpu_we : ldr_we;
        m_addr <= m_cpu_wins ? cpu_addr : ldr_addr;
        m_wdata <= m_cpu_wins ? cpu_wdata : ldr_wdata;
      end
    end else if (m_k == W + 2) begin
      m_busy <= 0;
      m_own <= 0;
    end else begin
      if (m_k == W + 1) begin
        if (m_we) mmem[m_addr] <= m_wdata;
        else if (m_own == 2'b01) m_cpu_rd <= mmem[m_addr];
        else m_ldr_rd <= mmem[m_addr];
      end
      m_k <= m_k + 1;
    end
  int en_cnt = 0, cpu_ack_cnt = 0, ldr_ack_cnt = 0;
  logic prev_en = 0;
  logic [1:0] grants[$];
  always @(negedge clk) begin
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("cpu_ack", 32'(cpu_ack), 32'(e_cack));
    chk("ldr_ack", 32'(ldr_ack), 32'(e_lack));
    chk("owner", 32'(owner), 32'(m_own));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rd));
    chk("ldr_rdata", 32'(ldr_rdata), 32'(m_ldr_rd));
    chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_cack));
    if (e_en) begin
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    end
    if (mem_en && !prev_en) grants.push_back(owner);
    prev_en <= mem_en;
    en_cnt <= en_cnt + 32'(mem_en);
    cpu_ack_cnt <= cpu_ack_cnt + 32'(cpu_ack);
    ldr_ack_cnt <= ldr_ack_cnt + 32'(ldr_ack);
  end
  task automatic cpu_txn(input logic we, input logic [7:0] a, input logic [15:0] d, output int lat);
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1; lat = 0;
    do begin @(negedge clk); lat++; end while (!cpu_ack && lat < 50);
    chk("cpu_ack_timeout", 32'(cpu_ack), 32'd1);
    @(posedge clk); #1 cpu_req = 0;
  endtask
  task automatic ldr_txn(input logic we, input logic [7:0] a, input logic [15:0] d, output int lat);
    ldr_we = we; ldr_addr = a; ldr_wdata = d; ldr_req = 1; lat = 0;
    do begin @(negedge clk); lat++; end while (!ldr_ack && lat < 50);
    chk("ldr_ack_timeout", 32'(ldr_ack), 32'd1);
    @(posedge clk); #1 ldr_req = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, n0, a0, k0;
    int cl[2], ll[2];
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_en", 32'(mem_en), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_ldr_rdata", 32'(ldr_rdata), 32'd0);
    @(posedge clk); #1;
    n0 = en_cnt;
    cpu_txn(0, 8'h10, 16'h0, lat);
    chk("cpu_rd_lat", 32'(lat), 32'd4);
    chk("cpu_rd_data", 32'(cpu_rdata), 32'h1234);
    chk("cpu_rd_en_cycles", 32'(en_cnt - n0), 32'd2);
    a0 = ldr_ack_cnt;
    ldr_txn(1, 8'h20, 16'hBEEF, lat);
    chk("ldr_wr_lat", 32'(lat), 32'd4);
    chk("ldr_wr_ack_count", 32'(ldr_ack_cnt - a0), 32'd1);
    chk("ldr_wr_keeps_cpu_rdata", 32'(cpu_rdata), 32'h1234);
    cpu_txn(0, 8'h20, 16'h0, lat);
    chk("cpu_rd_after_wr", 32'(cpu_rdata), 32'hBEEF);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    grants.delete();
    fork
      begin for (int i = 0; i < 2; i++) cpu_txn(0, 8'h10, 16'h0, cl[i]); end
      begin for (int j = 0; j < 2; j++) ldr_txn(0, 8'h30, 16'h0, ll[j]); end
    join
    chk("tie_cpu_lat0", 32'(cl[0]), 32'd4);
    chk("tie_ldr_lat0", 32'(ll[0]), 32'd8);
    chk("tie_cpu_lat1", 32'(cl[1]), 32'd8);
    chk("tie_ldr_lat1", 32'(ll[1]), 32'd8);
    chk("grant_count", 32'(grants.size()), 32'd4);
    if (grants.size() == 4) begin
      chk("grant0", 32'(grants[0]), 32'd1);
      chk("grant1", 32'(grants[1]), 32'd2);
      chk("grant2", 32'(grants[2]), 32'd1);
      chk("grant3", 32'(grants[3]), 32'd2);
    end
    chk("ldr_rd_data", 32'(ldr_rdata), 32'h5678);
    k0 = cpu_ack_cnt;
    cpu_we = 0; cpu_addr = 8'h30; cpu_req = 1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("abort_access2_en", 32'(mem_en), 32'd1);
    @(posedge clk); #1 rst = 0; cpu_req = 0;
    @(negedge clk);
    chk("abort_en", 32'(mem_en), 32'd0);
    chk("abort_owner", 32'(owner), 32'd0);
    chk("abort_cpu_rdata", 32'(cpu_rdata), 32'd0);
    @(negedge clk);
    chk("abort_no_ack", 32'(cpu_ack_cnt - k0), 32'd0);
    @(posedge clk); #1;
    grants.delete();
    fork
      cpu_txn(0, 8'h10, 16'h0, cl[0]);
      ldr_txn(0, 8'h30, 16'h0, ll[0]);
    join
    chk("post_abort_cpu_first", 32'(grants.size() > 0 ? grants[0] : 2'b00), 32'd1);
    chk("post_abort_cpu_lat", 32'(cl[0]), 32'd4);
    cpu_we = 0; cpu_addr = 8'h10; cpu_req = 1;
    @(posedge clk); #1 cpu_addr = 8'h30;
    @(negedge clk);
    chk("addr_change_held", 32'(mem_addr), 32'h10);
    lat = 0;
    while (!cpu_ack && lat < 50) begin @(negedge clk); lat++; end
    chk("addr_change_ack", 32'(cpu_ack), 32'd1);
    chk("addr_change_data", 32'(cpu_rdata), 32'h1234);
    @(posedge clk); #1 cpu_req = 0;
    n0 = 0; lat = 0;
    c0_addr = 8'h10; c0_req = 1;
    do begin @(negedge clk); lat++; n0 += 32'(m0_en); end while (!c0_ack && lat < 50);
    chk("w0_ack_lat", 32'(lat), 32'd3);
    chk("w0_en_cycles", 32'(n0), 32'd1);
    chk("w0_rdata", 32'(c0_rdata), 32'h1234);
    @(posedge clk); #1 c0_req = 0;
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
